seq_fsm_onehot_mo_detect: RTL

- Parametrised, registered Moore FSM that detects a compile-time serial bit pattern on a 1-bit input, MSB of the pattern first.
- State is held one-hot, N+1 states for an N-bit pattern.
- Generalises the fixed 4-state one-hot Moore block: pattern length is parametrised, overlapping vs non-overlapping detection is runtime-selectable, a saturating match counter is included, and illegal one-hot states recover automatically.
- Used as a reusable protocol/sync-word detector in serial front-ends.

---
 rtl/seq_fsm_pkg.sv | 36 +++
 rtl/seq_fsm_onehot_next.sv | 28 ++
 rtl/seq_fsm_onehot_mo_detect.sv | 50 +++++
 3 files changed

// File: rtl/seq_fsm_pkg.sv
// seq_fsm_pkg: shared constants and elaboration-time helpers for the one-hot pattern detector.
package seq_fsm_pkg;
  localparam int MAX_NBITS = 16;
  localparam int MAX_W = MAX_NBITS + 1;
  localparam int S0 = 0;
  // Longest prefix of the pattern that ends the history "first k pattern bits, then b".
  function automatic int kmp_next(logic [MAX_NBITS-1:0] pat, int n, int k, logic b);
    int r, i;
    logic ok, c;
    r = 0;
    for (int j = 1; j <= k + 1; j++) begin
      ok = 1'b1;
      for (int t = 0; t < j; t++) begin
        i = k + 1 - j + t;
        c = (i == k) ? b : pat[n-1-i];
        ok = ok & (c == pat[n-1-t]);
      end
      if (ok) r = j;
    end
    return r;
  endfunction
  function automatic int kmp_failure(logic [MAX_NBITS-1:0] pat, int n);
    int r;
    logic ok;
    r = 0;
    for (int j = 1; j < n; j++) begin
      ok = 1'b1;
      for (int t = 0; t < j; t++) ok = ok & (pat[n-1-t] == pat[j-1-t]);
      if (ok) r = j;
    end
    return r;
  endfunction
  function automatic logic is_onehot(logic [MAX_W-1:0] v);
    return $onehot(v);
  endfunction
endpackage

// File: rtl/seq_fsm_onehot_next.sv
// seq_fsm_onehot_next: combinational one-hot next-state and Moore output for the pattern detector.
module seq_fsm_onehot_next
  import seq_fsm_pkg::*;
#(
  parameter int NBITS = 4,
  parameter logic [NBITS-1:0] PATTERN = 4'b1101
) (
  input  logic [NBITS:0] state,
  input  logic           in_,
  input  logic           overlap,
  output logic [NBITS:0] state_next,
  output logic           out
);
  localparam int F = kmp_failure(MAX_NBITS'(PATTERN), NBITS);
  logic [NBITS:0] tgt [NBITS+1];
  for (genvar k = 0; k < NBITS; k++) begin : g_row
    localparam logic [NBITS:0] T0 = (NBITS+1)'(1) << kmp_next(MAX_NBITS'(PATTERN), NBITS, k, 1'b0);
    localparam logic [NBITS:0] T1 = (NBITS+1)'(1) << kmp_next(MAX_NBITS'(PATTERN), NBITS, k, 1'b1);
    assign tgt[k] = in_ ? T1 : T0;
  end
  // A full match behaves like its border state (overlap) or like S0 (restart).
  assign tgt[NBITS] = overlap ? tgt[F] : tgt[S0];
  always_comb begin
    state_next = '0;
    for (int k = 0; k <= NBITS; k++) state_next = state_next | (state[k] ? tgt[k] : '0);
  end
  assign out = state[NBITS];
endmodule

// File: rtl/seq_fsm_onehot_mo_detect.sv
// seq_fsm_onehot_mo_detect: registered one-hot Moore serial pattern detector with match counter and illegal-state recovery.
module seq_fsm_onehot_mo_detect
  import seq_fsm_pkg::*;
#(
  parameter int NBITS = 4,
  parameter logic [NBITS-1:0] PATTERN = 4'b1101,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             in_,
  input  logic             overlap,
  input  logic             clear,
  output logic [NBITS:0]   state,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             err
);
  localparam logic [NBITS:0] S0_OH = (NBITS+1)'(1) << S0;
  logic [NBITS:0] state_q, nxt, state_d;
  logic [CNT_W-1:0] cnt_d;
  logic valid, hit;
  seq_fsm_onehot_next #(.NBITS(NBITS), .PATTERN(PATTERN)) u_next (
    .state(state),
    .in_(in_),
    .overlap(overlap),
    .state_next(nxt),
    .out(out)
  );
  assign state = state_q;
  // An upset state recovers to S0 even while disabled and never counts.
  always_comb begin
    valid = is_onehot(MAX_W'(state));
    state_d = !valid ? S0_OH : en ? nxt : state;
    hit = valid && en && nxt[NBITS];
    cnt_d = clear ? '0 : (hit && match_count != '1) ? match_count + 1'b1 : match_count;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S0_OH;
      match_count <= '0;
      err <= 1'b0;
    end else begin
      state_q <= state_d;
      match_count <= cnt_d;
      err <= !valid;
    end
  end
endmodule
